// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared types and constants for the Clause 22 MDIO responder
package mdio_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_WDATA,
        S_RDATA,
        S_DRAIN
    } state_t;

    localparam logic [1:0]  OP_READ  = 2'b10;
    localparam logic [1:0]  OP_WRITE = 2'b01;

    localparam logic [15:0] REG0_RST = 16'h1140;
    localparam logic [15:0] REG1_RST = 16'h796D;

    // Running count of post-preamble bits consumed once the last bit of each field is sampled
    localparam logic [5:0]  BIT_OP_END    = 6'd4;
    localparam logic [5:0]  BIT_PHY_END   = 6'd9;
    localparam logic [5:0]  BIT_REG_END   = 6'd14;
    localparam logic [5:0]  BIT_TA1       = 6'd15;
    localparam logic [5:0]  BIT_FRAME_END = 6'd32;

endpackage

// File: rtl/mdc_edge_detect.sv
// rtl/mdc_edge_detect.sv - MDC/MDIO synchronisers and registered MDC rise pulse
// o_mdio is aligned with o_rise: it is the MDIO level present at the same pin time as the MDC rise.
module mdc_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_mdc,
    input  logic i_mdio,
    output logic o_rise,
    output logic o_mdio
);

    logic r_mdc_s1;
    logic r_mdc_s2;
    logic r_mdc_s3;
    logic r_mdio_s1;
    logic r_mdio_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mdc_s1  <= 1'b0;
            r_mdc_s2  <= 1'b0;
            r_mdc_s3  <= 1'b0;
            r_mdio_s1 <= 1'b0;
            r_mdio_s2 <= 1'b0;
            o_rise    <= 1'b0;
            o_mdio    <= 1'b0;
        end else begin
            r_mdc_s1  <= i_mdc;
            r_mdc_s2  <= r_mdc_s1;
            r_mdc_s3  <= r_mdc_s2;
            r_mdio_s1 <= i_mdio;
            r_mdio_s2 <= r_mdio_s1;
            o_rise    <= r_mdc_s2 & ~r_mdc_s3;
            o_mdio    <= r_mdio_s2;
        end
    end

endmodule

// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - Clause 22 MDIO responder with a 32 x 16 register bank
// Optional MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN: one 1 bit suffices as preamble after a completed frame.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2,
    parameter int          PREAMBLE_MIN = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        wr_valid,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        rd_valid
);

    localparam int PRE_W = $clog2(PREAMBLE_MIN + 1);
    localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(PREAMBLE_MIN);
`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN
    localparam logic [PRE_W-1:0] PRE_AFTER_FRAME = PRE_W'(PREAMBLE_MIN - 1);
`else
    localparam logic [PRE_W-1:0] PRE_AFTER_FRAME = '0;
`endif

    logic        w_rise;
    logic        w_bit;
    logic [5:0]  w_cnt_nxt;
    logic [1:0]  w_op_nxt;
    logic [4:0]  w_phy_nxt;
    logic [4:0]  w_reg_nxt;
    logic [15:0] w_sh_nxt;

    state_t           r_state;
    logic [PRE_W-1:0] r_pre;
    logic [5:0]       r_cnt;
    logic [1:0]       r_op;
    logic [4:0]       r_phy;
    logic [4:0]       r_reg;
    logic             r_ta1;
    logic [15:0]      r_sh;
    logic [15:0]      r_bank [0:31];

    mdc_edge_detect u_edge (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_mdc   (mdc),
        .i_mdio  (mdio_i),
        .o_rise  (w_rise),
        .o_mdio  (w_bit)
    );

    assign w_cnt_nxt = r_cnt + 6'd1;
    assign w_op_nxt  = {r_op[0], w_bit};
    assign w_phy_nxt = {r_phy[3:0], w_bit};
    assign w_reg_nxt = {r_reg[3:0], w_bit};
    assign w_sh_nxt  = {r_sh[14:0], w_bit};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pre    <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_phy    <= '0;
            r_reg    <= '0;
            r_ta1    <= 1'b0;
            r_sh     <= '0;
            mdio_o   <= 1'b0;
            mdio_oe  <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_valid <= 1'b0;
            for (int i = 0; i < 32; i++) r_bank[i] <= 16'h0000;
            r_bank[0] <= REG0_RST;
            r_bank[1] <= REG1_RST;
            r_bank[2] <= PHY_ID1;
            r_bank[3] <= PHY_ID2;
        end else begin
            wr_valid <= 1'b0;
            rd_valid <= 1'b0;
            // Reset bit of the control register reads back as 0 once the write has landed
            if (wr_valid && wr_addr == 5'd0) r_bank[0][15] <= 1'b0;
            if (w_rise) begin
                if (r_state != S_IDLE) r_cnt <= w_cnt_nxt;
                case (r_state)
                    S_IDLE: begin
                        if (w_bit) begin
                            if (r_pre < PRE_MIN) r_pre <= r_pre + PRE_W'(1);
                        end else if (r_pre >= PRE_MIN) begin
                            r_state <= S_ST;
                            r_cnt   <= 6'd1;
                        end else begin
                            r_pre <= '0;
                        end
                    end
                    S_ST: begin
                        if (w_bit) begin
                            r_state <= S_OP;
                        end else begin
                            r_state <= S_IDLE;
                            r_pre   <= '0;
                        end
                    end
                    S_OP: begin
                        r_op <= w_op_nxt;
                        if (w_cnt_nxt == BIT_OP_END)
                            r_state <= (w_op_nxt == OP_READ || w_op_nxt == OP_WRITE) ? S_PHYAD : S_DRAIN;
                    end
                    S_PHYAD: begin
                        r_phy <= w_phy_nxt;
                        if (w_cnt_nxt == BIT_PHY_END)
                            r_state <= (w_phy_nxt == PHY_ADDR) ? S_REGAD : S_DRAIN;
                    end
                    S_REGAD: begin
                        r_reg <= w_reg_nxt;
                        if (w_cnt_nxt == BIT_REG_END) r_state <= S_TA;
                    end
                    S_TA: begin
                        if (w_cnt_nxt == BIT_TA1) begin
                            r_ta1 <= w_bit;
                            if (r_op == OP_READ) begin
                                mdio_oe  <= 1'b1;
                                mdio_o   <= 1'b0;
                                rd_valid <= 1'b1;
                                r_sh     <= r_bank[r_reg];
                            end
                        end else if (r_op == OP_READ) begin
                            mdio_o  <= r_sh[15];
                            r_sh    <= {r_sh[14:0], 1'b0};
                            r_state <= S_RDATA;
                        end else begin
                            r_state <= (r_ta1 && !w_bit) ? S_WDATA : S_DRAIN;
                        end
                    end
                    S_RDATA: begin
                        if (w_cnt_nxt == BIT_FRAME_END) begin
                            mdio_oe <= 1'b0;
                            mdio_o  <= 1'b0;
                            r_state <= S_IDLE;
                            r_pre   <= PRE_AFTER_FRAME;
                        end else begin
                            mdio_o <= r_sh[15];
                            r_sh   <= {r_sh[14:0], 1'b0};
                        end
                    end
                    S_WDATA: begin
                        r_sh <= w_sh_nxt;
                        if (w_cnt_nxt == BIT_FRAME_END) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= r_reg;
                            wr_data  <= w_sh_nxt;
                            if (r_reg != 5'd2 && r_reg != 5'd3) r_bank[r_reg] <= w_sh_nxt;
                            r_state  <= S_IDLE;
                            r_pre    <= PRE_AFTER_FRAME;
                        end
                    end
                    S_DRAIN: begin
                        if (w_cnt_nxt == BIT_FRAME_END) begin
                            r_state <= S_IDLE;
                            r_pre   <= PRE_AFTER_FRAME;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_pre   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - self-checking bench for mdio_responder
module tb_mdio_responder;
    import mdio_pkg::*;

`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN
    localparam bit SUPP = 1'b1;
`else
    localparam bit SUPP = 1'b0;
`endif
    localparam int HALF = 4;
    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] WR = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mdc;
    logic        r_mst;
    logic        w_bus;
    logic        mdio_o;
    logic        mdio_oe;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_valid;

    int checks = 0;
    int errors = 0;
    int rdv_cnt = 0;
    int wrv_cnt = 0;
    logic [4:0]  last_wa = '0;
    logic [15:0] last_wd = '0;
    logic [15:0] m_bank [32];

    typedef struct {
        int         pre;
        logic [1:0] op;
        logic [4:0] phy;
        logic [4:0] rg;
        logic [1:0] ta;
        logic [15:0] wd;
        int         exp_oe;
        logic       exp_rdv;
        logic       exp_wrv;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t tbl [16];

    assign w_bus = mdio_oe ? mdio_o : r_mst;

    mdio_responder dut (
        .clock    (clk),
        .reset    (rst_n),
        .mdc      (mdc),
        .mdio_i   (w_bus),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_valid) rdv_cnt <= rdv_cnt + 1;
        if (wr_valid) begin
            wrv_cnt <= wrv_cnt + 1;
            last_wa <= wr_addr;
            last_wd <= wr_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic mbit(input logic b, output logic s, output logic oe);
        r_mst = b;
        repeat (HALF) @(negedge clk);
        s  = w_bus;
        oe = mdio_oe;
        mdc = 1'b1;
        repeat (HALF) @(negedge clk);
        mdc = 1'b0;
    endtask

    function automatic logic [31:0] frame_bits(input logic [1:0] op, input logic [4:0] phy,
                                               input logic [4:0] rg, input logic [1:0] ta,
                                               input logic [15:0] wd);
        if (op == RD) return {2'b01, op, phy, rg, 2'b11, 16'hFFFF};
        return {2'b01, op, phy, rg, ta, wd};
    endfunction

    // Master view of one frame: bus samples of the data field, TA bit 2, driven bit periods, pulse counts
    task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] wd,
                             output logic [15:0] rd, output logic ta2, output int oe_bits,
                             output int rdv, output int wrv);
        logic [31:0] fb;
        logic s, oe;
        int rdv0, wrv0;
        rdv0 = rdv_cnt;
        wrv0 = wrv_cnt;
        fb = frame_bits(op, phy, rg, ta, wd);
        for (int i = 0; i < pre; i++) mbit(1'b1, s, oe);
        oe_bits = 0;
        rd = '0;
        ta2 = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            mbit(fb[i], s, oe);
            if (oe) oe_bits++;
            if (i == 16) ta2 = s;
            if (i < 16) rd = {rd[14:0], s};
        end
        repeat (4) @(negedge clk);
        rdv = rdv_cnt - rdv0;
        wrv = wrv_cnt - wrv0;
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        logic [15:0] rd;
        logic ta2;
        int oe_bits, rdv, wrv;
        logic exp_ta2;
        run_frame(v.pre, v.op, v.phy, v.rg, v.ta, v.wd, rd, ta2, oe_bits, rdv, wrv);
        exp_ta2 = v.exp_rdv ? 1'b0 : ((v.op == RD) ? 1'b1 : v.ta[0]);
        chk({tag, " oe_bits"}, 32'(oe_bits), 32'(v.exp_oe));
        chk({tag, " rd_valid_pulses"}, 32'(rdv), 32'(v.exp_rdv));
        chk({tag, " wr_valid_pulses"}, 32'(wrv), 32'(v.exp_wrv));
        chk({tag, " data_bus"}, 32'(rd), 32'(v.exp_rd));
        chk({tag, " ta2_bus"}, 32'(ta2), 32'(exp_ta2));
        if (v.exp_wrv) begin
            chk({tag, " wr_addr"}, 32'(last_wa), 32'(v.rg));
            chk({tag, " wr_data"}, 32'(last_wd), 32'(v.wd));
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 32; i++) m_bank[i] = 16'h0000;
        m_bank[0] = 16'h1140;
        m_bank[1] = 16'h796D;
        m_bank[2] = 16'h0141;
        m_bank[3] = 16'h0CC2;
    endtask

    initial begin
        vec_t v;
        logic [31:0] fb;
        logic s, oe;
        rst_n = 1'b0;
        mdc   = 1'b0;
        r_mst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset mdio_o", 32'(mdio_o), 32'd0);
        chk("reset mdio_oe", 32'(mdio_oe), 32'd0);
        chk("reset wr_valid", 32'(wr_valid), 32'd0);
        chk("reset wr_addr", 32'(wr_addr), 32'd0);
        chk("reset wr_data", 32'(wr_data), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        tbl[0]  = '{32, RD, 5'd1, 5'd2, 2'b11, 16'h0000, 17, 1'b1, 1'b0, 16'h0141};
        tbl[1]  = '{32, WR, 5'd1, 5'd4, 2'b10, 16'hA5A5, 0, 1'b0, 1'b1, 16'hA5A5};
        tbl[2]  = '{32, RD, 5'd1, 5'd4, 2'b11, 16'h0000, 17, 1'b1, 1'b0, 16'hA5A5};
        tbl[3]  = '{32, WR, 5'd1, 5'd4, 2'b11, 16'h5A5A, 0, 1'b0, 1'b0, 16'h5A5A};
        tbl[4]  = '{32, RD, 5'd1, 5'd4, 2'b11, 16'h0000, 17, 1'b1, 1'b0, 16'hA5A5};
        tbl[5]  = '{32, RD, 5'd7, 5'd4, 2'b11, 16'h0000, 0, 1'b0, 1'b0, 16'hFFFF};
        tbl[6]  = '{31, RD, 5'd1, 5'd2, 2'b11, 16'h0000, SUPP ? 17 : 0, SUPP, 1'b0,
                    SUPP ? 16'h0141 : 16'hFFFF};
        tbl[7]  = '{32, WR, 5'd1, 5'd0, 2'b10, 16'h8000, 0, 1'b0, 1'b1, 16'h8000};
        tbl[8]  = '{32, RD, 5'd1, 5'd0, 2'b11, 16'h0000, 17, 1'b1, 1'b0, 16'h0000};
        tbl[9]  = '{32, RD, 5'd1, 5'd1, 2'b11, 16'h0000, 17, 1'b1, 1'b0, 16'h796D};
        tbl[10] = '{32, RD, 5'd1, 5'd3, 2'b11, 16'h0000, 17, 1'b1, 1'b0, 16'h0CC2};
        tbl[11] = '{32, WR, 5'd1, 5'd2, 2'b10, 16'hFFFF, 0, 1'b0, 1'b1, 16'hFFFF};
        tbl[12] = '{32, RD, 5'd1, 5'd2, 2'b11, 16'h0000, 17, 1'b1, 1'b0, 16'h0141};
        tbl[13] = '{32, 2'b11, 5'd1, 5'd4, 2'b10, 16'h1234, 0, 1'b0, 1'b0, 16'h1234};
        tbl[14] = '{32, 2'b00, 5'd1, 5'd4, 2'b10, 16'h4321, 0, 1'b0, 1'b0, 16'h4321};
        tbl[15] = '{32, RD, 5'd1, 5'd4, 2'b11, 16'h0000, 17, 1'b1, 1'b0, 16'hA5A5};
        for (int i = 0; i < 16; i++) check_frame($sformatf("vec%0d", i), tbl[i]);

        // Back-to-back read with a single preamble bit, then a normally preambled read
        v = '{1, RD, 5'd1, 5'd1, 2'b11, 16'h0000, SUPP ? 17 : 0, SUPP, 1'b0,
              SUPP ? 16'h796D : 16'hFFFF};
        check_frame("short_pre", v);
        v = '{32, RD, 5'd1, 5'd1, 2'b11, 16'h0000, 17, 1'b1, 1'b0, 16'h796D};
        check_frame("after_short", v);

        // Reset in the middle of the read data phase
        fb = frame_bits(RD, 5'd1, 5'd4, 2'b11, 16'h0000);
        for (int i = 0; i < 32; i++) mbit(1'b1, s, oe);
        for (int i = 31; i >= 13; i--) mbit(fb[i], s, oe);
        chk("mid_rdata oe_before_reset", 32'(oe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rdata oe_after_reset", 32'(mdio_oe), 32'd0);
        chk("mid_rdata o_after_reset", 32'(mdio_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        v = '{32, RD, 5'd1, 5'd4, 2'b11, 16'h0000, 17, 1'b1, 1'b0, 16'h0000};
        check_frame("post_reset_reg4", v);
        v = '{32, RD, 5'd1, 5'd0, 2'b11, 16'h0000, 17, 1'b1, 1'b0, 16'h1140};
        check_frame("post_reset_reg0", v);

        // Randomised frames against a register-bank model
        model_init();
        for (int n = 0; n < 40; n++) begin
            int sel;
            logic acc;
            sel   = $urandom_range(0, 9);
            v.op  = (sel < 4) ? RD : (sel < 8) ? WR : (sel == 8) ? 2'b00 : 2'b11;
            v.phy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd1;
            v.rg  = 5'($urandom);
            v.ta  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b10;
            v.wd  = 16'($urandom);
            v.pre = $urandom_range(32, 36);
            acc       = (v.op == RD || v.op == WR) && v.phy == 5'd1;
            v.exp_rdv = acc && v.op == RD;
            v.exp_wrv = acc && v.op == WR && v.ta == 2'b10;
            v.exp_oe  = v.exp_rdv ? 17 : 0;
            v.exp_rd  = v.exp_rdv ? m_bank[v.rg] : (v.op == RD) ? 16'hFFFF : v.wd;
            check_frame($sformatf("rand%0d", n), v);
            if (v.exp_wrv && v.rg != 5'd2 && v.rg != 5'd3)
                m_bank[v.rg] = (v.rg == 5'd0) ? (v.wd & 16'h7FFF) : v.wd;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_responder.md
# mdio_responder

Clause 22 MDIO management responder (PHY-side end of the MDIO/MDC link driven by the Ethernet management master). Oversamples MDC/MDIO in the system clock domain, decodes read and write frames addressed to its PHY address, serves them from an internal 32 x 16 register bank, and notifies the fabric of every accepted write. Sits alongside gig_eth_pcs_pma as the management target for the SGMII path and as an in-fabric PHY model for system simulation.

## Interface
- PHY_ADDR, 5'd1, PHY address this responder answers to
- PHY_ID1, 16'h0141, read-only value of register 2
- PHY_ID2, 16'h0CC2, read-only value of register 3
- PREAMBLE_MIN, 32, consecutive MDIO ones required before ST
- clock  in  1  system clock, at least 4x MDC frequency
- reset  in  1  asynchronous, active-low reset
- mdc  in  1  management clock from master, asynchronous to clock
- mdio_i  in  1  MDIO pad input
- mdio_o  out  1  MDIO pad output value
- mdio_oe  out  1  MDIO pad output enable (1 = drive)
- wr_valid  out  1  one-cycle pulse: register write committed
- wr_addr  out  5  register address of committed write
- wr_data  out  16  data of committed write
- rd_valid  out  1  one-cycle pulse: read frame accepted, data shift starting

## Operation
- mdc and mdio_i pass through 2-flop synchronisers; MDC rising edge detected from synchronised samples; all frame logic advances only on a detected rise, sampling synchronised MDIO.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, DRAIN.
- IDLE: count consecutive ones (saturating at PREAMBLE_MIN); a 0 with count >= PREAMBLE_MIN moves to ST (this 0 is ST bit 1); a 0 with count < PREAMBLE_MIN clears count.
- ST: expect 1; else back to IDLE, count cleared.
- OP: 2 bits; 10 = read, 01 = write; 00/11 -> DRAIN.
- PHYAD, REGAD: 5 bits each, MSB first. PHYAD != PHY_ADDR -> frame continues through DRAIN with no drive and no write.
- TA (read): first TA bit ignored; responder drives 0 for second bit, then RDATA drives 16 bits MSB first.
- TA (write): must sample 1 then 0; otherwise DRAIN without committing.
- WDATA: shift 16 bits; after 16th bit commit to bank (registers 2/3 unchanged) and pulse wr_valid with wr_addr/wr_data regardless of read-only status.
- DRAIN: count remaining bits of a 32-bit post-preamble frame without driving, then IDLE with count cleared.
- Bank reset values: reg0 = 16'h1140, reg1 = 16'h796D, reg2 = PHY_ID1, reg3 = PHY_ID2, others 0. Reg0 bit 15 self-clears one clock after commit.

## Timing
- Reset values: mdio_o 0, mdio_oe 0, wr_valid 0, wr_addr 0, wr_data 0, rd_valid 0; state IDLE, preamble count 0.
- Rise detection latency: 3 clock cycles from mdc pin edge.
- Read: mdio_oe and mdio_o=0 asserted 1 cycle after detected rise sampling TA bit 1; each next bit updated 1 cycle after the detected rise sampling the previous bit; mdio_oe released 1 cycle after detected rise sampling D0 (17 bit periods driven). rd_valid pulses with mdio_oe assertion; read data latched from bank at that cycle.
- Write: wr_valid pulses 1 cycle after detected rise sampling D0.
- MDC stalled mid-frame: state held indefinitely, outputs held.
- reset asserted mid-frame: immediate release of mdio_oe, bank reinitialised, IDLE.

## Configuration
- MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN defined: after any completed frame (RDATA/WDATA/DRAIN end), a single 1 bit is sufficient preamble for the next frame; initial frame after reset still needs PREAMBLE_MIN.
- Undefined: every frame requires PREAMBLE_MIN ones.

## Structure
- Package mdio_pkg: state enum, opcode constants (OP_READ 2'b10, OP_WRITE 2'b01), register reset-value constants, frame bit-count constants.
- Sub-module mdc_edge_detect: 2-flop synchronisers for mdc/mdio_i plus rise-pulse generation.

## Test plan
- 32 ones, read PHYAD 1 REGAD 2 -> mdio_oe for 17 bits, TA 0 then 16'h0141 MSB first, rd_valid one pulse.
- Write PHYAD 1 REGAD 4 data 16'hA5A5 with TA 10 -> wr_valid, wr_addr 4, wr_data 16'hA5A5; subsequent read of reg 4 returns 16'hA5A5.
- Write PHYAD 1 REGAD 4 with TA 11 -> no wr_valid, reg 4 unchanged; read to PHYAD 7 -> mdio_oe never asserted.
- Preamble of 31 ones then valid read -> ignored; write 16'h8000 to reg0 -> reads back 16'h0000 bit 15 cleared.
- Back-to-back reads with 1-bit preamble -> answered only with MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN; reset pulsed mid-RDATA -> mdio_oe 0 immediately, reg4 back to 0.
